// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the cache memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL_ISSUE,
    FILL_DRAIN
  } arb_state_t;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } owner_t;

  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORDS_PER_BLOCK   = 8;

  // Index of the final word of a block; both counters wrap past it.
  localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_BLOCK - 1);

  // Clears the byte offset within a 16-byte block.
  localparam logic [15:0] BLOCK_MASK = ~16'((1 << BLOCK_OFFSET_BITS) - 1);

endpackage

// File: rtl/adder_16bit.sv
// rtl/adder_16bit.sv - 16-bit adder, carry out discarded
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one pipelined memory port between I-fill, D-fill and D-store
module cache_mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_fill_req,
  input  logic [15:0] i_fill_addr,
  input  logic        d_fill_req,
  input  logic [15:0] d_fill_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_valid,
  output logic        d_fill_valid,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        i_busy,
  output logic        d_busy,
  output logic        d_wr_ack
);

  arb_state_t  state;
  arb_state_t  state_next;
  owner_t      owner;
  owner_t      last_owner;
  owner_t      grant_owner;
  logic        grant_fill;
  logic [15:0] grant_addr;
  logic [15:0] base;
  logic [15:0] issue_addr;
  logic [2:0]  issue_cnt;
  logic [2:0]  ret_cnt;
  logic        in_fill;
  logic        ret_valid;
  logic        last_ret;

  assign in_fill   = (state == FILL_ISSUE) || (state == FILL_DRAIN);
  // Returns outside a fill are strays and must not reach either cache.
  assign ret_valid = in_fill && mem_data_valid;
  assign last_ret  = ret_valid && (ret_cnt == LAST_WORD);

  adder_16bit u_addr_add (
    .a   (base),
    .b   ({12'h000, issue_cnt, 1'b0}),
    .sum (issue_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration, next state and memory-port drive.
  always_comb begin
    state_next  = state;
    grant_fill  = 1'b0;
    grant_owner = owner;
    grant_addr  = 16'h0000;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = 16'h0000;
    mem_wdata   = 16'h0000;
    d_wr_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (d_wr_req) begin
          state_next = WRITE;
        end else if (i_fill_req && d_fill_req) begin
          // Round robin: whoever filled last yields.
          grant_fill  = 1'b1;
          grant_owner = (last_owner == OWNER_I) ? OWNER_D : OWNER_I;
        end else if (i_fill_req) begin
          grant_fill  = 1'b1;
          grant_owner = OWNER_I;
        end else if (d_fill_req) begin
          grant_fill  = 1'b1;
          grant_owner = OWNER_D;
        end
        if (grant_fill) begin
          state_next = FILL_ISSUE;
          grant_addr = (grant_owner == OWNER_I) ? i_fill_addr : d_fill_addr;
        end
      end
      WRITE: begin
        mem_en     = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = d_wr_addr;
        mem_wdata  = d_wr_data;
        d_wr_ack   = 1'b1;
        state_next = IDLE;
      end
      FILL_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = issue_addr;
        if (issue_cnt == LAST_WORD) begin
          state_next = last_ret ? IDLE : FILL_DRAIN;
        end
      end
      FILL_DRAIN: begin
        if (last_ret) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Fill bookkeeping: owner, block base, issue and return counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner      <= OWNER_I;
      last_owner <= OWNER_I;
      base       <= 16'h0000;
      issue_cnt  <= 3'd0;
      ret_cnt    <= 3'd0;
    end else begin
      if (grant_fill) begin
        owner     <= grant_owner;
        base      <= grant_addr & BLOCK_MASK;
        issue_cnt <= 3'd0;
        ret_cnt   <= 3'd0;
      end
      if (state == FILL_ISSUE) begin
        issue_cnt <= issue_cnt + 3'd1;
      end
      if (ret_valid) begin
        ret_cnt <= ret_cnt + 3'd1;
      end
      if (last_ret) begin
        last_owner <= owner;
      end
    end
  end

  assign fill_data    = ret_valid ? mem_rdata : 16'h0000;
  assign fill_word    = ret_cnt;
  assign i_fill_valid = ret_valid && (owner == OWNER_I);
  assign d_fill_valid = ret_valid && (owner == OWNER_D);
  assign i_fill_done  = last_ret && (owner == OWNER_I);
  assign d_fill_done  = last_ret && (owner == OWNER_D);
  assign i_busy       = i_fill_req || (in_fill && (owner == OWNER_I));
  assign d_busy       = d_fill_req || (in_fill && (owner == OWNER_D)) ||
                        (d_wr_req && !d_wr_ack);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_fill_req;
  logic [15:0] i_fill_addr;
  logic        d_fill_req;
  logic [15:0] d_fill_addr;
  logic        d_wr_req;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_data_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_valid;
  logic        d_fill_valid;
  logic        i_fill_done;
  logic        d_fill_done;
  logic        i_busy;
  logic        d_busy;
  logic        d_wr_ack;

  int errors = 0;
  int checks = 0;

  // Memory model: 4-cycle read pipeline, data = address ^ 0x5A5A.
  logic [3:0]  pipe_v;
  logic [15:0] pipe_a [4];
  logic        stray;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fill_req     (i_fill_req),
    .i_fill_addr    (i_fill_addr),
    .d_fill_req     (d_fill_req),
    .d_fill_addr    (d_fill_addr),
    .d_wr_req       (d_wr_req),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .mem_en         (mem_en),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_data_valid (mem_data_valid),
    .fill_data      (fill_data),
    .fill_word      (fill_word),
    .i_fill_valid   (i_fill_valid),
    .d_fill_valid   (d_fill_valid),
    .i_fill_done    (i_fill_done),
    .d_fill_done    (d_fill_done),
    .i_busy         (i_busy),
    .d_busy         (d_busy),
    .d_wr_ack       (d_wr_ack)
  );

  // Memory read pipeline, reset with the arbiter.
  always @(posedge clk) begin
    if (!rst_n) begin
      pipe_v <= 4'b0000;
      for (int s = 0; s < 4; s++) pipe_a[s] <= 16'h0000;
    end else begin
      pipe_v    <= {pipe_v[2:0], mem_en & ~mem_wr};
      pipe_a[0] <= mem_addr;
      pipe_a[1] <= pipe_a[0];
      pipe_a[2] <= pipe_a[1];
      pipe_a[3] <= pipe_a[2];
    end
  end

  assign mem_data_valid = pipe_v[3] | stray;
  assign mem_rdata      = pipe_a[3] ^ 16'h5A5A;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Follows one granted fill from its first issue cycle (j=1) to its done cycle (j=12).
  task automatic fill_cycles(input logic [15:0] base, input bit is_i, input bit keep);
    logic own_v, oth_v, own_d, oth_d, own_b;
    for (int j = 1; j <= 12; j++) begin
      tick();
      own_v = is_i ? i_fill_valid : d_fill_valid;
      oth_v = is_i ? d_fill_valid : i_fill_valid;
      own_d = is_i ? i_fill_done  : d_fill_done;
      oth_d = is_i ? d_fill_done  : i_fill_done;
      own_b = is_i ? i_busy       : d_busy;
      chk("fill_mem_en", 32'(mem_en), 32'(j <= 8));
      if (j <= 8) begin
        chk("fill_mem_wr", 32'(mem_wr), 32'd0);
        chk("fill_mem_addr", 32'(mem_addr), 32'(base + 16'(2 * (j - 1))));
      end
      chk("fill_own_valid", 32'(own_v), 32'(j >= 5));
      chk("fill_oth_valid", 32'(oth_v), 32'd0);
      if (j >= 5) begin
        chk("fill_word", 32'(fill_word), 32'(j - 5));
        chk("fill_data", 32'(fill_data), 32'((base + 16'(2 * (j - 5))) ^ 16'h5A5A));
      end
      chk("fill_own_done", 32'(own_d), 32'(j == 12));
      chk("fill_oth_done", 32'(oth_d), 32'd0);
      chk("fill_own_busy", 32'(own_b), 32'd1);
    end
    if (!keep) begin
      if (is_i) i_fill_req = 1'b0;
      else      d_fill_req = 1'b0;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_i_valid"}, 32'(i_fill_valid), 32'd0);
    chk({tag, "_d_valid"}, 32'(d_fill_valid), 32'd0);
    chk({tag, "_i_done"}, 32'(i_fill_done), 32'd0);
    chk({tag, "_d_done"}, 32'(d_fill_done), 32'd0);
    chk({tag, "_fill_data"}, 32'(fill_data), 32'd0);
    chk({tag, "_fill_word"}, 32'(fill_word), 32'd0);
    chk({tag, "_wr_ack"}, 32'(d_wr_ack), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    i_fill_req  = 1'b0;
    i_fill_addr = 16'h0000;
    d_fill_req  = 1'b0;
    d_fill_addr = 16'h0000;
    d_wr_req    = 1'b0;
    d_wr_addr   = 16'h0000;
    d_wr_data   = 16'h0000;
    stray       = 1'b0;
    tick();
    tick();
    chk_quiet("reset");
    chk("reset_i_busy", 32'(i_busy), 32'd0);
    chk("reset_d_busy", 32'(d_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Lone I fill at 0x1236.
    i_fill_req  = 1'b1;
    i_fill_addr = 16'h1236;
    #1;
    chk("t1_req_i_busy", 32'(i_busy), 32'd1);
    chk("t1_req_d_busy", 32'(d_busy), 32'd0);
    chk("t1_req_mem_en", 32'(mem_en), 32'd0);
    fill_cycles(16'h1230, 1'b1, 1'b0);
    tick();
    chk_quiet("t1_after");
    chk("t1_after_i_busy", 32'(i_busy), 32'd0);
    chk("t1_after_d_busy", 32'(d_busy), 32'd0);

    // Fresh reset, then simultaneous I and D fill: D first, then I.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    i_fill_req  = 1'b1;
    i_fill_addr = 16'h2000;
    d_fill_req  = 1'b1;
    d_fill_addr = 16'h3458;
    fill_cycles(16'h3450, 1'b0, 1'b0);
    tick();
    chk("t2_gap_mem_en", 32'(mem_en), 32'd0);
    chk("t2_gap_i_busy", 32'(i_busy), 32'd1);
    fill_cycles(16'h2000, 1'b1, 1'b0);

    // Four back-to-back fills with both requests held: D, I, D, I.
    tick();
    i_fill_req  = 1'b1;
    i_fill_addr = 16'h6100;
    d_fill_req  = 1'b1;
    d_fill_addr = 16'h7200;
    fill_cycles(16'h7200, 1'b0, 1'b1);
    tick();
    chk("t4_gap1_mem_en", 32'(mem_en), 32'd0);
    fill_cycles(16'h6100, 1'b1, 1'b1);
    tick();
    chk("t4_gap2_mem_en", 32'(mem_en), 32'd0);
    d_fill_addr = 16'h7310;
    fill_cycles(16'h7310, 1'b0, 1'b1);
    tick();
    chk("t4_gap3_mem_en", 32'(mem_en), 32'd0);
    i_fill_addr = 16'h6FFF;
    fill_cycles(16'h6FF0, 1'b1, 1'b0);
    d_fill_req = 1'b0;
    tick();

    // Store and fill together: store at N+1, fill issue from N+3.
    d_wr_req    = 1'b1;
    d_wr_addr   = 16'h0040;
    d_wr_data   = 16'hBEEF;
    d_fill_req  = 1'b1;
    d_fill_addr = 16'h4000;
    #1;
    chk("t3_req_d_busy", 32'(d_busy), 32'd1);
    tick();
    chk("t3_wr_mem_en", 32'(mem_en), 32'd1);
    chk("t3_wr_mem_wr", 32'(mem_wr), 32'd1);
    chk("t3_wr_addr", 32'(mem_addr), 32'h0040);
    chk("t3_wr_data", 32'(mem_wdata), 32'hBEEF);
    chk("t3_wr_ack", 32'(d_wr_ack), 32'd1);
    d_wr_req = 1'b0;
    tick();
    chk("t3_idle_mem_en", 32'(mem_en), 32'd0);
    chk("t3_idle_ack", 32'(d_wr_ack), 32'd0);
    fill_cycles(16'h4000, 1'b0, 1'b0);
    tick();

    // Reset during the 5th issue cycle of an I fill.
    i_fill_req  = 1'b1;
    i_fill_addr = 16'h5000;
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk("t5_issue_mem_en", 32'(mem_en), 32'd1);
      chk("t5_issue_addr", 32'(mem_addr), 32'(16'h5000 + 16'(2 * (j - 1))));
    end
    rst_n      = 1'b0;
    i_fill_req = 1'b0;
    tick();
    chk_quiet("t5_rst");
    chk("t5_rst_i_busy", 32'(i_busy), 32'd0);
    chk("t5_rst_d_busy", 32'(d_busy), 32'd0);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("t5_post_mem_en", 32'(mem_en), 32'd0);
      chk("t5_post_i_valid", 32'(i_fill_valid), 32'd0);
      chk("t5_post_i_done", 32'(i_fill_done), 32'd0);
    end

    // Stray return in IDLE is ignored and does not advance the word count.
    stray = 1'b1;
    #1;
    chk("t6_stray_i_valid", 32'(i_fill_valid), 32'd0);
    chk("t6_stray_d_valid", 32'(d_fill_valid), 32'd0);
    chk("t6_stray_fill_data", 32'(fill_data), 32'd0);
    tick();
    stray = 1'b0;
    chk("t6_after_word", 32'(fill_word), 32'd0);

    // Fresh I fill after the aborted one completes normally.
    i_fill_req  = 1'b1;
    i_fill_addr = 16'h1236;
    fill_cycles(16'h1230, 1'b1, 1'b0);
    tick();
    chk_quiet("t5_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
